fixed_point_multiply: RTL and testbench



---
 rtl/arith_pkg.sv | 16 +
 rtl/fixed_point_multiply.sv | 99 +++++++++
 tb/tb_fixed_point_multiply.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/arith_pkg.sv
// rtl/arith_pkg.sv - shared widths and FSM state encoding for the fixed-point divider/multiplier pair
package arith_pkg;

  localparam int A_W = 20;
  localparam int B_W = 3;
  localparam int P_W = A_W + B_W;
  localparam int I_W = 5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    MUL    = 2'd2,
    OUTPUT = 2'd3
  } state_e;

endpackage

// File: rtl/fixed_point_multiply.sv
// rtl/fixed_point_multiply.sv - sequential shift-add Q10.10 x uint3 multiplier with early termination
module fixed_point_multiply
  import arith_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  input  logic [A_W-1:0] in_data_1,
  input  logic [B_W-1:0] in_data_2,
  output logic           out_valid,
  output logic [P_W-1:0] out_data
);

  state_e         state_q, state_d;
  logic [A_W-1:0] a_q, a_d;
  logic [B_W-1:0] b_q, b_d;
  logic [A_W-1:0] a_sh_q, a_sh_d;
  logic [P_W-1:0] acc_q, acc_d;
  logic [I_W-1:0] i_q, i_d;
  logic           out_valid_q, out_valid_d;
  logic [P_W-1:0] out_data_q, out_data_d;
  logic [P_W-1:0] b_shifted;

  assign b_shifted = {{(P_W-B_W){1'b0}}, b_q} << i_q;

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    a_sh_d      = a_sh_q;
    acc_d       = acc_q;
    i_d         = i_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = in_data_1;
          b_d     = in_data_2;
          state_d = LOAD;
        end
      end
      LOAD: begin
        // Operands keep tracking the input while the strobe is held; last cycle wins.
        if (in_valid) begin
          a_d = in_data_1;
          b_d = in_data_2;
        end else begin
          acc_d   = '0;
          i_d     = '0;
          a_sh_d  = a_q;
          state_d = MUL;
        end
      end
      MUL: begin
        if (a_sh_q == '0) begin
          out_data_d  = acc_q;
          out_valid_d = 1'b1;
          state_d     = OUTPUT;
        end else begin
          if (a_sh_q[0]) acc_d = acc_q + b_shifted;
          a_sh_d = a_sh_q >> 1;
          i_d    = i_q + 1'b1;
        end
      end
      OUTPUT: begin
        out_valid_d = 1'b0;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      a_sh_q      <= '0;
      acc_q       <= '0;
      i_q         <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      a_sh_q      <= a_sh_d;
      acc_q       <= acc_d;
      i_q         <= i_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_fixed_point_multiply.sv
// tb/tb_fixed_point_multiply.sv - directed scoreboard bench for fixed_point_multiply
module tb_fixed_point_multiply;
  import arith_pkg::*;

  logic           clk;
  logic           rst;
  logic           in_valid;
  logic [A_W-1:0] in_data_1;
  logic [B_W-1:0] in_data_2;
  logic           out_valid;
  logic [P_W-1:0] out_data;

  int errors = 0;
  int checks = 0;
  logic [P_W-1:0] sb[$];

  fixed_point_multiply dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data_1 (in_data_1),
    .in_data_2 (in_data_2),
    .out_valid (out_valid),
    .out_data  (out_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Present one operand pair for one cycle; called at a negedge, returns at the next negedge.
  task automatic drive(input logic [A_W-1:0] a, input logic [B_W-1:0] b);
    in_valid  = 1'b1;
    in_data_1 = a;
    in_data_2 = b;
    @(negedge clk);
  endtask

  // Drops in_valid, counts edges until the strobe, checks data, latency and strobe width.
  task automatic finish_txn(input string tag, input int exp_lat, input bit poke_mul);
    int             lat;
    logic [P_W-1:0] exp_d;
    logic [P_W-1:0] held;
    in_valid = 1'b0;
    lat = 0;
    for (int e = 1; e <= 40; e++) begin
      @(posedge clk);
      #1;
      if (out_valid === 1'b1) begin
        lat = e;
        break;
      end
      if (poke_mul && e == 3) begin
        in_valid  = 1'b1;
        in_data_1 = 20'h00001;
        in_data_2 = 3'd1;
      end
      if (poke_mul && e == 4) in_valid = 1'b0;
    end
    exp_d = (sb.size() > 0) ? sb.pop_front() : '0;
    chk({tag, "_latency"}, lat, exp_lat);
    chk({tag, "_data"}, {9'd0, out_data}, {9'd0, exp_d});
    held = out_data;
    @(posedge clk);
    #1;
    chk({tag, "_strobe_drop"}, {31'd0, out_valid}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk({tag, "_hold"}, {9'd0, out_data}, {9'd0, held});
    @(negedge clk);
  endtask

  initial begin
    int strobes;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data_1 = '0;
    in_data_2 = '0;
    #3;
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_out_data", {9'd0, out_data}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // 6.0 * 5 = 30.0
    sb.push_back(23'h007800);
    drive(20'h01800, 3'd5);
    finish_txn("t1_6x5", 15, 1'b0);

    // zero multiplicand terminates immediately
    sb.push_back(23'h000000);
    drive(20'h00000, 3'd7);
    finish_txn("t2_zero", 2, 1'b0);

    // largest operands
    sb.push_back(23'h6FFFF9);
    drive(20'hFFFFF, 3'd7);
    finish_txn("t3_max", 22, 1'b0);

    // multi-cycle strobe: last pair wins
    sb.push_back(23'h002400);
    drive(20'h00400, 3'd1);
    drive(20'h00800, 3'd2);
    drive(20'h00C00, 3'd3);
    finish_txn("t4_relatch", 14, 1'b0);

    // reset mid-computation aborts with no strobe
    drive(20'h80000, 3'd3);
    in_valid = 1'b0;
    strobes  = 0;
    for (int e = 1; e <= 9; e++) begin
      @(posedge clk);
      #1;
      if (out_valid === 1'b1) strobes++;
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("t5_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("t5_rst_out_data", {9'd0, out_data}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int e = 0; e < 25; e++) begin
      @(posedge clk);
      #1;
      if (out_valid === 1'b1) strobes++;
    end
    chk("t5_no_strobe", strobes, 32'd0);
    @(negedge clk);
    sb.push_back(23'h000800);
    drive(20'h00400, 3'd2);
    finish_txn("t5_after_rst", 13, 1'b0);

    // round trip of divider output q = floor(1000*1024/3); in_valid during MUL ignored
    sb.push_back(23'd1023999);
    drive(20'h53555, 3'd3);
    finish_txn("t6_roundtrip", 21, 1'b1);
    chk("t6_integer_part", {19'd0, out_data[22:10]}, 32'd999);

    // the ignored pulse must not have started another transaction
    strobes = 0;
    for (int e = 0; e < 25; e++) begin
      @(posedge clk);
      #1;
      if (out_valid === 1'b1) strobes++;
    end
    chk("t6_no_extra_strobe", strobes, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
